// File: rtl/tiny86_pkg.sv
// tiny86_pkg: shared tiny86 trace-step geometry and loader state encoding
package tiny86_pkg;
    localparam int STEP_W    = 560;
    localparam int INSTR_LSB = 0;
    localparam int INSTR_W   = 96;
    localparam int REGS_LSB  = 96;
    localparam int REGS_W    = 320;
    localparam int HINT1_LSB = 416;
    localparam int HINT1_W   = 72;
    localparam int HINT2_LSB = 488;
    localparam int HINT2_W   = 72;
    typedef enum logic {FILL, DISCARD} loader_state_t;
endpackage

// File: rtl/tiny86_step_fifo.sv
// tiny86_step_fifo: register-array FIFO with wrapping pointers and occupancy count
module tiny86_step_fifo #(
    parameter int W     = 560,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;
    assign full   = r_level == LW'(DEPTH);
    assign empty  = r_level == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rp];
    assign level  = r_level;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= din;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
endmodule

// File: rtl/tiny86_step_loader.sv
// tiny86_step_loader: reassembles bus beats into trace steps, buffers them, flags framing errors
module tiny86_step_loader #(
    parameter int STEP_W = tiny86_pkg::STEP_W,
    parameter int BUS_W  = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BUS_W-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [STEP_W-1:0]            out_step,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             step_count,
    output logic                         err_frame
);
    import tiny86_pkg::*;
    localparam int BEATS = (STEP_W + BUS_W - 1) / BUS_W;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    loader_state_t               r_state;
    loader_state_t               w_state_nxt;
    logic [CW-1:0]               r_cnt;
    logic [CW-1:0]               w_cnt_nxt;
    logic [(BEATS-1)*BUS_W-1:0]  r_stage;
    logic [CNT_W-1:0]            r_count;
    logic                        r_err;
    logic                        w_acc;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_err;
    logic                        w_stage_we;
    logic                        w_full;
    logic                        w_empty;
    logic [STEP_W-1:0]           w_step;
    assign in_ready   = !clear && !(r_state == FILL && r_cnt == LAST && w_full);
    assign w_acc      = in_valid && in_ready;
    assign w_step     = STEP_W'({in_data, r_stage});
    assign out_valid  = !w_empty;
    assign w_pop      = out_valid && out_ready && !clear;
    assign step_count = r_count;
    assign err_frame  = r_err;
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_err       = 1'b0;
        w_stage_we  = 1'b0;
        if (w_acc) begin
            if (r_state == DISCARD) begin
                w_state_nxt = in_last ? FILL : DISCARD;
                w_cnt_nxt   = '0;
            end else if (r_cnt == LAST) begin
                w_push      = in_last;
                w_err       = !in_last;
                w_state_nxt = in_last ? FILL : DISCARD;
                w_cnt_nxt   = '0;
            end else begin
                w_err       = in_last;
                w_stage_we  = !in_last;
                w_cnt_nxt   = in_last ? '0 : r_cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_count <= r_count + CNT_W'(w_push);
            r_err   <= r_err | w_err;
        end
    end
    // the final beat bypasses staging and goes straight into the FIFO with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage <= '0;
        else for (int i = 0; i < BEATS - 1; i++)
            if (w_stage_we && r_cnt == CW'(i)) r_stage[i*BUS_W +: BUS_W] <= in_data;
    end
    tiny86_step_fifo #(.W(STEP_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_step),
        .dout  (out_step),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );
endmodule
